// File: rtl/seg7_pkg.sv
// Shared seven-segment types and active-low hex glyph constants (bit0 = a ... bit6 = g).
package seg7_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output seg_t                seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex display scanner with tear-free shadow/display double buffering.
// Optional leading-zero blanking is built when SEG7_LZ_SUPPRESS_EN is defined.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 25000,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]          i_dp,
  input  logic                           i_load,
  input  logic                           i_enable,
  output logic [SEG_W-1:0]               o_seg,
  output logic                           o_dp,
  output logic [NUM_DIGITS-1:0]          o_an,
  output logic                           o_pending
);

  localparam int unsigned DATA_W   = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_LAST = REFRESH_DIV - 1;
  localparam int unsigned IDX_LAST = NUM_DIGITS - 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_d;
  seg_t                  seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  logic                  cnt_last;
  logic                  idx_last;
  logic                  wrap;
  logic                  transfer;
  logic [NIBBLE_W-1:0]   sel_nibble;
  logic                  sel_dp;
  logic [NUM_DIGITS-1:0] an_hot;
  seg_t                  dec_seg_c;

  // Glyph of the digit currently addressed by idx.
  seg7_hex_decode u_decode (
    .nibble (sel_nibble),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    an_hot     = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      an_hot[k] = (idx_q == IDX_W'(k));
      if (idx_q == IDX_W'(k)) begin
        sel_nibble = disp_data_q[k*NIBBLE_W +: NIBBLE_W];
        sel_dp     = disp_dp_q[k];
      end
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;
  logic                  sel_lz;

  // A digit is blank while it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    sel_lz  = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz_run     = lz_run && (disp_data_q[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_mask[k] = lz_run;
    end
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_lz = lz_mask[k];
      end
    end
  end
`endif

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = o_pending;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    an_d          = AN_OFF;

    cnt_last = (cnt_q == CNT_W'(CNT_LAST));
    idx_last = (idx_q == IDX_W'(IDX_LAST));
    wrap     = i_enable && cnt_last && idx_last;
    // Frame boundary, or immediately when the display is dark.
    transfer = o_pending && (wrap || !i_enable);

    if (!i_enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (transfer) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
    end
    if (i_load) begin
      shadow_data_d = i_data;
      shadow_dp_d   = i_dp;
      pending_d     = 1'b1;
    end

    if (i_enable) begin
`ifdef SEG7_LZ_SUPPRESS_EN
      seg_d = sel_lz ? SEG_BLANK : dec_seg_c;
`else
      seg_d = dec_seg_c;
`endif
      dp_d  = ~sel_dp;
      // First cycle of every slot is dead time against ghosting.
      if (cnt_q != '0) begin
        an_d = AN_OFF ^ an_hot;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      o_pending     <= 1'b0;
      o_seg         <= SEG_BLANK;
      o_dp          <= 1'b1;
      o_an          <= AN_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      o_pending     <= pending_d;
      o_seg         <= seg_d;
      o_dp          <= dp_d;
      o_an          <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle slots, active-low anodes).
module tb_seven_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   i_data;
  logic [3:0]    i_dp;
  logic          i_load;
  logic          i_enable;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic [3:0]    o_an;
  logic          o_pending;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (RD),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (i_data),
    .i_dp      (i_dp),
    .i_load    (i_load),
    .i_enable  (i_enable),
    .o_seg     (o_seg),
    .o_dp      (o_dp),
    .o_an      (o_an),
    .o_pending (o_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] data, input int d);
    logic [3:0] nib;
    nib = data[d*4 +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (d != 0 && (data >> (4*d)) == 16'h0) return 7'b1111111;
`endif
    return glyph(nib);
  endfunction

  // Walks one full frame from the cycle after a wrap; loads fire at frame positions idx*4+cnt.
  task automatic check_frame(input string tag, input logic [15:0] data, input logic [3:0] dp,
                             input int ld1_pos, input logic [15:0] ld1_data,
                             input int ld2_pos, input logic [15:0] ld2_data);
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 4; j++) begin
        int         p;
        logic       loaded;
        logic [3:0] exp_an;
        logic       exp_dp;
        p      = d*4 + j;
        loaded = 1'b0;
        if (p == ld1_pos) begin i_data = ld1_data; i_load = 1'b1; loaded = 1'b1; end
        if (p == ld2_pos) begin i_data = ld2_data; i_load = 1'b1; loaded = 1'b1; end
        @(negedge clk);
        i_load = 1'b0;
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        exp_dp = ~dp[d];
        if (j == 0) begin
          check($sformatf("%s d%0d dead an", tag, d), 32'(o_an), 32'h0000_000F);
        end else begin
          check($sformatf("%s d%0d c%0d an", tag, d, j), 32'(o_an), 32'(exp_an));
          check($sformatf("%s d%0d c%0d seg", tag, d, j), 32'(o_seg), 32'(exp_seg(data, d)));
          check($sformatf("%s d%0d c%0d dp", tag, d, j), 32'(o_dp), 32'(exp_dp));
        end
        if (loaded) check($sformatf("%s pending after load", tag), 32'(o_pending), 32'd1);
      end
    end
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    i_enable = 1'b0;
    i_load   = 1'b0;
    i_data   = 16'h0;
    i_dp     = 4'h0;
    repeat (3) @(negedge clk);
    check("reset an", 32'(o_an), 32'h0000_000F);
    check("reset seg", 32'(o_seg), 32'h0000_007F);
    check("reset dp", 32'(o_dp), 32'd1);
    check("reset pending", 32'(o_pending), 32'd0);

    rst_n    = 1'b1;
    i_enable = 1'b1;
    @(negedge clk);
    i_data = 16'h12AF;
    i_dp   = 4'b0100;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    i_dp   = 4'h0;
    check("12AF pending set", 32'(o_pending), 32'd1);

    t = 0;
    while (o_pending && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("12AF transfer at wrap", 32'(o_pending), 32'd0);

    check_frame("12AF", 16'h12AF, 4'b0100, -1, 16'h0, -1, 16'h0);
    check_frame("12AF_hold", 16'h12AF, 4'b0100, 5, 16'h3333, -1, 16'h0);
    check("3333 pending clear", 32'(o_pending), 32'd0);
    check_frame("3333", 16'h3333, 4'h0, 2, 16'h4444, 15, 16'h5555);
    check("wrap load keeps pending", 32'(o_pending), 32'd1);
    check_frame("4444", 16'h4444, 4'h0, -1, 16'h0, -1, 16'h0);
    check("5555 pending clear", 32'(o_pending), 32'd0);
    check_frame("5555", 16'h5555, 4'h0, 1, 16'h0005, -1, 16'h0);
    check_frame("0005", 16'h0005, 4'h0, 1, 16'h0000, -1, 16'h0);
    check_frame("0000", 16'h0000, 4'h0, -1, 16'h0, -1, 16'h0);

    // Drop enable inside slot 1.
    repeat (6) @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    check("disable an", 32'(o_an), 32'h0000_000F);
    check("disable seg", 32'(o_seg), 32'h0000_007F);
    i_data = 16'h0007;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    check("dark load pending", 32'(o_pending), 32'd1);
    @(negedge clk);
    check("dark transfer", 32'(o_pending), 32'd0);
    i_enable = 1'b1;
    @(negedge clk);
    check("resume dead an", 32'(o_an), 32'h0000_000F);
    @(negedge clk);
    check("resume digit0 an", 32'(o_an), 32'h0000_000E);
    check("resume digit0 seg", 32'(o_seg), 32'(7'b1111000));

    // Asynchronous reset mid-scan with pending data.
    i_data = 16'h0009;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    check("pre-reset pending", 32'(o_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset an", 32'(o_an), 32'h0000_000F);
    check("async reset seg", 32'(o_seg), 32'h0000_007F);
    check("async reset dp", 32'(o_dp), 32'd1);
    check("async reset pending", 32'(o_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset dead an", 32'(o_an), 32'h0000_000F);
    @(negedge clk);
    check("post-reset digit0 an", 32'(o_an), 32'h0000_000E);
    check("post-reset discard seg", 32'(o_seg), 32'(7'b1000000));
    check("post-reset pending", 32'(o_pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 25000, clock cycles per digit slot; legal range >= 2.
REQ-003 Parameter AN_ACTIVE_LOW, default 1, digit-enable polarity: 1 means a digit is on when its bit is 0.
REQ-004 i_clk  input  1  single clock; all state rises on its posedge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_data  input  4*NUM_DIGITS  hex nibbles; nibble k = i_data[4k+3:4k] drives digit k, where digit 0 is least significant.
REQ-007 i_dp  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 i_load  input  1  one-cycle strobe; captures i_data and i_dp into the shadow register.
REQ-009 i_enable  input  1  1 = scanning; 0 = display dark.
REQ-010 o_seg  output  7  segments, active-low; bit0=a through bit6=g.
REQ-011 o_dp  output  1  decimal point, active-low.
REQ-012 o_an  output  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
REQ-013 o_pending  output  1  shadow holds data not yet shown.

Function
REQ-014 Glyphs SHALL follow the hex table 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; a blank digit is 1111111.
REQ-015 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and then return to 0; on that terminal count, idx SHALL advance to (idx+1) mod NUM_DIGITS.
REQ-016 A wrap event SHALL be defined as cnt==REFRESH_DIV-1 && idx==NUM_DIGITS-1 && i_enable.
REQ-017 On i_load, the shadow register SHALL take i_data/i_dp in the next cycle, and o_pending SHALL be set.
REQ-018 On a wrap event with o_pending=1, the display register SHALL take the shadow value, and o_pending SHALL clear, so a frame never tears.
REQ-019 When i_load and a wrap coincide, the display register SHALL take the old shadow value, the shadow SHALL take the new data, and o_pending SHALL remain 1.
REQ-020 Repeated i_load while pending SHALL overwrite the shadow; only the last value is shown.
REQ-021 o_seg, o_dp and o_an SHALL be registered with 1-cycle latency from (cnt, idx).
REQ-022 The o_an bit idx SHALL be active while cnt != 0; all o_an bits SHALL be inactive when cnt==0 (dead time against ghosting).
REQ-023 When i_enable=0, cnt and idx SHALL be held at 0, and o_an SHALL be all inactive.
REQ-024 When i_enable=0 with o_pending=1, the transfer SHALL occur on the next cycle.

Reset
REQ-025 On i_rst_n low, the following SHALL be reset immediately:
- cnt=0, idx=0
- shadow=0, display=0, o_pending=0
- o_seg=1111111, o_dp=1
- o_an all inactive

REQ-026 After reset release, scanning SHALL restart from digit 0; a reset mid-frame SHALL discard pending data.

Configuration
REQ-027 With macro SEG7_LZ_SUPPRESS_EN defined, leading-zero suppression SHALL apply to the displayed value:
- each most-significant zero nibble is blanked, up to the first nonzero nibble
- digit 0 is never blanked
- blanked digits still honour i_dp

REQ-028 Without SEG7_LZ_SUPPRESS_EN, every digit SHALL show its glyph, zeros included, and the suppression logic SHALL be absent.

Structure
REQ-029 Package seg7_pkg SHALL hold:
- the 16 glyph constants
- SEG_BLANK
- the typedef seg_t (7-bit)

REQ-030 Nibble decoding SHALL live in sub-module seg7_hex_decode, one instance fed by the selected display nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1)
REQ-031 Assert reset mid-scan -> same cycle o_an=1111, o_seg=1111111, o_dp=1, o_pending=0.
REQ-032 i_enable=1, i_load with i_data=16'h12AF, i_dp=4'b0100 -> after the next wrap, slots show:
- an=1110, seg=0001110
- an=1101, seg=0001000
- an=1011, seg=0100100, o_dp=0
- an=0111, seg=1111001

Each slot has 3 active cycles and 1 dead cycle.
REQ-033 i_load 16'h3333 at idx=1 during a frame showing 16'h12AF -> o_pending=1, and 16'h12AF is shown unchanged until the wrap; then 16'h3333 is shown and o_pending=0.
REQ-034 i_load 16'h5555 on the exact wrap cycle while shadow=16'h4444 -> the next frame shows 4444, o_pending stays 1, and the frame after shows 5555.
REQ-035 Load 16'h0005 and then 16'h0000:
- with SEG7_LZ_SUPPRESS_EN, digits 3..1 show 1111111; digit 0 shows 0010010, then 1000000
- without the macro, digits 3..1 show 1000000

REQ-036 Drop i_enable mid-slot -> the next cycle has o_an=1111; restore it -> scanning resumes at digit 0, cnt 0.
